// File: rtl/fpu_pipe_ctrl.sv
// Issue/collect controller for a fixed-latency, non-stallable FPU unit: credit-gated intake,
// valid/tag shadow pipeline, in-order result FIFO. Optional flush port: define FPU_PIPE_FLUSH_EN.
module fpu_pipe_ctrl #(
   parameter int LATENCY = 7,
   parameter int TAG_W   = 5,
   parameter int DEPTH   = 8
) (
   input  logic             clk,
   input  logic             rst,
`ifdef FPU_PIPE_FLUSH_EN
   input  logic             flush,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_x,
   input  logic [TAG_W-1:0] in_tag,
   output logic [31:0]      unit_x,
   input  logic [31:0]      unit_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_y,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   logic               flush_s;
   logic               fire_s;
   logic               pop_s;
   logic               cap_s;
   logic [LATENCY-1:0] sh_vld_q, sh_vld_d;
   logic [TAG_W-1:0]   sh_tag_q [LATENCY];
   logic [TAG_W-1:0]   sh_tag_d [LATENCY];
   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [CW-1:0]      occ_q, occ_d;
   logic [31:0]        mem_y_q   [DEPTH];
   logic [TAG_W-1:0]   mem_tag_q [DEPTH];

`ifdef FPU_PIPE_FLUSH_EN
   assign flush_s = flush;
`else
   assign flush_s = 1'b0;
`endif

   // Credits span in-flight ops plus FIFO entries, so a capture always finds a free slot.
   assign unit_x    = in_x;
   assign in_ready  = !rst && !flush_s && (cnt_q < DEPTH_C);
   assign fire_s    = in_valid & in_ready;
   assign out_valid = (occ_q != {CW{1'b0}}) && !flush_s;
   assign pop_s     = out_valid & out_ready;
   assign cap_s     = sh_vld_q[LATENCY-1];
   assign out_y     = mem_y_q[rd_ptr_q];
   assign out_tag   = mem_tag_q[rd_ptr_q];
   assign busy      = (cnt_q != {CW{1'b0}});

   // Shadow pipeline mirrors the unit's fixed latency; it never stalls.
   always_comb begin
      sh_vld_d    = {LATENCY{1'b0}};
      sh_tag_d[0] = in_tag;
      for (int i = 1; i < LATENCY; i++) begin
         sh_tag_d[i] = sh_tag_q[i-1];
      end
      if (!flush_s) begin
         sh_vld_d[0] = fire_s;
         for (int i = 1; i < LATENCY; i++) begin
            sh_vld_d[i] = sh_vld_q[i-1];
         end
      end else begin
         sh_vld_d = {LATENCY{1'b0}};
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      occ_d    = occ_q;
      if (flush_s) begin
         wr_ptr_d = {PW{1'b0}};
         rd_ptr_d = {PW{1'b0}};
         cnt_d    = {CW{1'b0}};
         occ_d    = {CW{1'b0}};
      end else begin
         if (cap_s) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? {PW{1'b0}} : wr_ptr_q + PW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? {PW{1'b0}} : rd_ptr_q + PW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({fire_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
         case ({cap_s, pop_s})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_vld_q <= {LATENCY{1'b0}};
         for (int i = 0; i < LATENCY; i++) begin
            sh_tag_q[i] <= {TAG_W{1'b0}};
         end
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         cnt_q    <= {CW{1'b0}};
         occ_q    <= {CW{1'b0}};
      end else begin
         sh_vld_q <= sh_vld_d;
         for (int i = 0; i < LATENCY; i++) begin
            sh_tag_q[i] <= sh_tag_d[i];
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         occ_q    <= occ_d;
      end
   end

   // Result storage; a write landing during reset/flush is harmless since the pointers clear.
   always_ff @(posedge clk) begin
      if (cap_s) begin
         mem_y_q[wr_ptr_q]   <= unit_y;
         mem_tag_q[wr_ptr_q] <= sh_tag_q[LATENCY-1];
      end
   end

endmodule

// File: tb/tb_fpu_pipe_ctrl.sv
// Bench for fpu_pipe_ctrl driving an ffloor unit model; directed scenarios then random traffic,
// all checked against a queue-based reference. Flush scenario compiled when FPU_PIPE_FLUSH_EN is set.
module tb_fpu_pipe_ctrl;
   localparam int LAT   = 7;
   localparam int TAG_W = 5;
   localparam int DEPTH = 8;

   logic             clk = 1'b0;
   logic             rst;
`ifdef FPU_PIPE_FLUSH_EN
   logic             flush;
`endif
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_x;
   logic [TAG_W-1:0] in_tag;
   logic [31:0]      unit_x;
   logic [31:0]      unit_y;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_y;
   logic [TAG_W-1:0] out_tag;
   logic             busy;

   always #5 clk = ~clk;

   fpu_pipe_ctrl #(.LATENCY(LAT), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
`ifdef FPU_PIPE_FLUSH_EN
      .flush(flush),
`endif
      .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_tag(in_tag),
      .unit_x(unit_x), .unit_y(unit_y),
      .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_tag(out_tag),
      .busy(busy)
   );

   // IEEE single floor, bit-level.
   function automatic logic [31:0] ffloor(input logic [31:0] x);
      logic [7:0]  e;
      logic [31:0] m;
      logic [31:0] r;
      e = x[30:23];
      if (e == 8'hFF || e >= 8'd150) return x;
      if (e < 8'd127) begin
         if (x[30:0] == 31'd0) return x;
         return x[31] ? 32'hBF800000 : 32'h00000000;
      end
      m = (32'd1 << (8'd150 - e)) - 32'd1;
      if ((x & m) == 32'd0) return x;
      r = x & ~m;
      if (x[31]) r = r + m + 32'd1;
      return r;
   endfunction

   // Unit model: non-stallable, fixed latency, no reset.
   logic [31:0] upipe [LAT];
   always @(posedge clk) begin
      upipe[0] <= ffloor(unit_x);
      for (int i = 1; i < LAT; i++) upipe[i] <= upipe[i-1];
   end
   assign unit_y = upipe[LAT-1];

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [31:0]      y;
      int               avail;
   } exp_t;

   exp_t        q[$];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          obs_fires = 0;
   int          last_pop_cyc = -1;
   logic [31:0] last_y = 32'd0;
   logic [TAG_W-1:0] last_tag = '0;
   int          t_start;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   // One clock cycle: drive, check at negedge against the reference, advance the reference.
   task automatic step(input logic r, input logic fl, input logic v, input logic [31:0] x,
                       input logic [TAG_W-1:0] t, input logic ordy);
      logic exp_rdy;
      logic exp_ov;
      rst = r; in_valid = v; in_x = x; in_tag = t; out_ready = ordy;
`ifdef FPU_PIPE_FLUSH_EN
      flush = fl;
`endif
      @(negedge clk);
      exp_rdy = !r && !fl && (q.size() < DEPTH);
      exp_ov  = 1'b0;
      if (!fl && q.size() != 0) begin
         if (q[0].avail <= cyc) exp_ov = 1'b1;
      end
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      chk("unit_x", unit_x, x);
      if (!r) begin
         chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
         chk("busy", {31'd0, busy}, {31'd0, q.size() != 0});
         if (exp_ov) begin
            chk("out_y", out_y, q[0].y);
            chk("out_tag", {27'd0, out_tag}, {27'd0, q[0].tag});
         end
      end
      if (in_valid && in_ready) obs_fires++;
      if (out_valid && out_ready) begin
         last_y = out_y; last_tag = out_tag; last_pop_cyc = cyc;
      end
      if (r || fl) begin
         q.delete();
      end else begin
         if (exp_ov && ordy) void'(q.pop_front());
         if (v && exp_rdy) q.push_back('{tag: t, y: ffloor(x), avail: cyc + LAT + 1});
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic ordy);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0, '0, ordy);
   endtask

   initial begin
      logic [31:0] rx;
      logic        rr, rf, rv, ro;
      rst = 1'b1; in_valid = 1'b0; in_x = 32'd0; in_tag = '0; out_ready = 1'b0;
`ifdef FPU_PIPE_FLUSH_EN
      flush = 1'b0;
`endif
      // Reset, including a request held during reset.
      step(1'b1, 1'b0, 1'b0, 32'd0, '0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 32'd0, '0, 1'b0);
      obs_fires = 0;
      step(1'b1, 1'b0, 1'b1, 32'h3F800000, 5'd1, 1'b1);
      chk("rst_no_accept", obs_fires, 32'd0);
      idle(2, 1'b1);

      // Single op latency.
      t_start = cyc; last_pop_cyc = -1;
      step(1'b0, 1'b0, 1'b1, 32'h40490FDB, 5'd3, 1'b1);
      idle(10, 1'b1);
      chk("t2_y", last_y, 32'h40400000);
      chk("t2_tag", {27'd0, last_tag}, 32'd3);
      chk("t2_lat", last_pop_cyc - t_start, LAT + 1);

      // Back-to-back.
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 32'hBFC00000, 5'(i), 1'b1);
      idle(10, 1'b1);
      chk("t3_last_y", last_y, 32'hC0000000);
      chk("t3_last_tag", {27'd0, last_tag}, 32'd7);

      // Credit exhaustion with stalled consumer.
      obs_fires = 0;
      for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, 32'h41200000 + 32'(i), 5'(i), 1'b0);
      chk("t4_accepts", obs_fires, 32'd8);
      step(1'b0, 1'b0, 1'b0, 32'd0, '0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 32'h40000000, 5'd20, 1'b0);
      step(1'b0, 1'b0, 1'b1, 32'h40000000, 5'd21, 1'b0);
      chk("t4_accepts2", obs_fires, 32'd9);
      idle(20, 1'b1);

      // Reset mid-operation.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 32'h40A00000, 5'(i + 10), 1'b1);
      idle(1, 1'b1);
      step(1'b1, 1'b0, 1'b0, 32'd0, '0, 1'b1);
      last_pop_cyc = -1;
      idle(12, 1'b1);
      chk("t5_no_stale", last_pop_cyc, -1);
      t_start = cyc;
      step(1'b0, 1'b0, 1'b1, 32'h3F800000, 5'd9, 1'b1);
      idle(10, 1'b1);
      chk("t5_y", last_y, 32'h3F800000);
      chk("t5_lat", last_pop_cyc - t_start, LAT + 1);

`ifdef FPU_PIPE_FLUSH_EN
      // Flush with 2 results buffered and 4 in flight.
      step(1'b0, 1'b0, 1'b1, 32'h40F00000, 5'd1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 32'h40F00000, 5'd2, 1'b0);
      idle(4, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 32'h41000000, 5'(i + 3), 1'b0);
      step(1'b0, 1'b1, 1'b1, 32'h41000000, 5'd8, 1'b1);
      last_pop_cyc = -1;
      idle(15, 1'b1);
      chk("t6_no_stale", last_pop_cyc, -1);
`endif

      // Random traffic.
      for (int n = 0; n < 800; n++) begin
         rr = ($urandom_range(99) == 0);
`ifdef FPU_PIPE_FLUSH_EN
         rf = ($urandom_range(59) == 0);
`else
         rf = 1'b0;
`endif
         rv = ($urandom_range(3) != 0);
         ro = ((n / 50) % 3 == 1) ? ($urandom_range(7) == 0) : ($urandom_range(3) != 0);
         rx = $urandom;
         if (rx[0]) rx[30:23] = 8'(120 + $urandom_range(40));
         step(rr, rf, rv, rx, TAG_W'($urandom), ro);
      end
      idle(20, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
